// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt gateway
package irq_pkg;
  typedef enum logic [1:0] {GW_IDLE, GW_ISSUE, GW_WAIT} gw_state_e;
  localparam int GW_RESERVED_ID = 0;
endpackage

// File: rtl/irq_gateway_ch.sv
// irq_gateway_ch: one interrupt source with synchroniser, edge queue and issue/wait FSM
module irq_gateway_ch
  import irq_pkg::*;
#(
  parameter int sync = 2,
  parameter int cw = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_en,
  input  logic cmp,
  input  logic ovf_clr,
  output logic int_o,
  output logic inflight_o,
  output logic ovf_o
);
  logic [sync-1:0] sh;
  logic prev;
  logic [cw-1:0] cnt;
  gw_state_e st, nxt;
  logic s, e, req, go, sat;
  // a fresh edge can issue in the cycle it is seen, keeping edge latency equal to level latency
  assign s = sh[sync-1];
  assign e = s & ~prev;
  assign req = edge_en ? (cnt != '0 || e) : s;
  assign go = st == GW_IDLE && req;
  assign sat = &cnt;
  always_comb nxt = st == GW_IDLE ? (req ? GW_ISSUE : GW_IDLE) : (cmp ? GW_IDLE : GW_WAIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      prev <= 1'b0;
      cnt <= '0;
      st <= GW_IDLE;
      int_o <= 1'b0;
      inflight_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      sh <= {sh[sync-2:0], src};
      prev <= s;
      st <= nxt;
      int_o <= nxt == GW_ISSUE;
      inflight_o <= nxt != GW_IDLE;
      cnt <= !edge_en ? '0 : (e && !go && !sat) ? cnt + 1'b1 : (go && !e) ? cnt - 1'b1 : cnt;
      ovf_o <= (edge_en && e && !go && sat) || (ovf_o && !ovf_clr);
    end
  end
endmodule

// File: rtl/irq_gateway.sv
// irq_gateway: per-source gateway between raw device interrupts and the PLIC int_vect input
module irq_gateway
  import irq_pkg::*;
#(
  parameter int ndev = 8,
  parameter int sync = 2,
  parameter int cw = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ndev-1:0]         irq_src,
  input  logic [ndev-1:0]         cfg_edge,
  input  logic                    cmp_valid,
  input  logic [$clog2(ndev)-1:0] cmp_id,
  input  logic                    ovf_clr,
  output logic [ndev-1:0]         int_vect,
  output logic [ndev-1:0]         inflight,
  output logic [ndev-1:0]         ovf
);
  localparam int IW = $clog2(ndev);
  logic unused_rsv;
  assign unused_rsv = ^{irq_src[GW_RESERVED_ID], cfg_edge[GW_RESERVED_ID]};
  assign int_vect[GW_RESERVED_ID] = 1'b0;
  assign inflight[GW_RESERVED_ID] = 1'b0;
  assign ovf[GW_RESERVED_ID] = 1'b0;
  for (genvar i = GW_RESERVED_ID + 1; i < ndev; i++) begin : g_ch
    logic cmp;
    assign cmp = cmp_valid && cmp_id == IW'(i);
    irq_gateway_ch #(.sync(sync), .cw(cw)) u_ch (
      .clk(clk),
      .rst(rst),
      .src(irq_src[i]),
      .edge_en(cfg_edge[i]),
      .cmp(cmp),
      .ovf_clr(ovf_clr),
      .int_o(int_vect[i]),
      .inflight_o(inflight[i]),
      .ovf_o(ovf[i])
    );
  end
endmodule
